// File: rtl/fetch.sv
// ============================================================================
// fetch : instruction fetch stage with imem handshake, 1-entry skid buffer,
//         and branch/jump redirect with decoder flush.  Revision 1.0
// ============================================================================
`default_nettype none

module fetch #(
   parameter int                     IWIDTH   = 32,
   parameter int                     PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
   parameter logic [IWIDTH-1:0]      NOP      = 32'h0000_0013
) (
   input  logic                f_clk,
   input  logic                f_rst,
   output logic                f_o_imem_req,
   output logic [PC_WIDTH-1:0] f_o_imem_addr,
   input  logic                f_i_imem_ack,
   input  logic [IWIDTH-1:0]   f_i_imem_instr,
   input  logic                f_i_change_pc,
   input  logic [PC_WIDTH-1:0] f_i_pc_target,
   input  logic                f_i_stall,
   output logic [IWIDTH-1:0]   f_o_instr,
   output logic [PC_WIDTH-1:0] f_o_pc,
   output logic                f_o_ce,
   output logic                f_o_flush
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                req_q, req_d;
   logic [PC_WIDTH-1:0] addr_q, addr_d;
   logic [IWIDTH-1:0]   instr_q, instr_d;
   logic [PC_WIDTH-1:0] opc_q, opc_d;
   logic                ce_q, ce_d;
   logic                flush_q, flush_d;
   logic [IWIDTH-1:0]   buf_instr_q, buf_instr_d;
   logic [PC_WIDTH-1:0] buf_pc_q, buf_pc_d;

   logic [PC_WIDTH-1:0] target_w;
   logic [PC_WIDTH-1:0] addr_inc_w;

   assign target_w   = {f_i_pc_target[PC_WIDTH-1:2], 2'b00};
   assign addr_inc_w = addr_q + PC_WIDTH'(4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_d       = req_q;
      addr_d      = addr_q;
      instr_d     = instr_q;
      opc_d       = opc_q;
      ce_d        = ce_q;
      flush_d     = 1'b0;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;

      if (f_i_change_pc) begin
         pc_d    = target_w;
         flush_d = 1'b1;
         ce_d    = 1'b0;
         instr_d = NOP;
         // An unacked request must still complete on the bus; its response is dropped.
         if ((state_q == REQ || state_q == DROP) && !f_i_imem_ack) begin
            state_d = DROP;
         end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = target_w;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
            REQ: begin
               if (f_i_stall) begin
                  if (f_i_imem_ack) begin
                     buf_instr_d = f_i_imem_instr;
                     buf_pc_d    = addr_q;
                     pc_d        = addr_inc_w;
                     req_d       = 1'b0;
                     state_d     = HOLD;
                  end
               end else if (f_i_imem_ack) begin
                  instr_d = f_i_imem_instr;
                  opc_d   = addr_q;
                  ce_d    = 1'b1;
                  pc_d    = addr_inc_w;
                  addr_d  = addr_inc_w;
               end else begin
                  ce_d = 1'b0;
               end
            end
            HOLD: begin
               if (!f_i_stall) begin
                  instr_d = buf_instr_q;
                  opc_d   = buf_pc_q;
                  ce_d    = 1'b1;
                  req_d   = 1'b1;
                  addr_d  = pc_q;
                  state_d = REQ;
               end
            end
            DROP: begin
               if (f_i_imem_ack) begin
                  req_d   = 1'b1;
                  addr_d  = pc_q;
                  state_d = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge f_clk or posedge f_rst) begin
      if (f_rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_q       <= 1'b0;
         addr_q      <= RESET_PC;
         instr_q     <= NOP;
         opc_q       <= '0;
         ce_q        <= 1'b0;
         flush_q     <= 1'b0;
         buf_instr_q <= NOP;
         buf_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         instr_q     <= instr_d;
         opc_q       <= opc_d;
         ce_q        <= ce_d;
         flush_q     <= flush_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   assign f_o_imem_req  = req_q;
   assign f_o_imem_addr = addr_q;
   assign f_o_instr     = instr_q;
   assign f_o_pc        = opc_q;
   assign f_o_ce        = ce_q;
   assign f_o_flush     = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
// tb_fetch : directed vector bench for the fetch stage.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch;

   localparam logic [31:0] NOP_C = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ack = 1'b0;
   logic        chg = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] tgt = '0;
   logic        req;
   logic [31:0] addr;
   logic [31:0] imem_instr;
   logic [31:0] instr;
   logic [31:0] opc;
   logic        ce;
   logic        flush;

   logic        rst2 = 1'b1;
   logic        ack2 = 1'b0;
   logic        req2;
   logic [31:0] addr2;
   logic [31:0] instr2;
   logic [31:0] opc2;
   logic        ce2;
   logic        flush2;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   // Memory returns a word tagged with its own address.
   assign imem_instr = 32'hA000_0000 | addr;

   fetch dut (
      .f_clk          (clk),
      .f_rst          (rst),
      .f_o_imem_req   (req),
      .f_o_imem_addr  (addr),
      .f_i_imem_ack   (ack),
      .f_i_imem_instr (imem_instr),
      .f_i_change_pc  (chg),
      .f_i_pc_target  (tgt),
      .f_i_stall      (stall),
      .f_o_instr      (instr),
      .f_o_pc         (opc),
      .f_o_ce         (ce),
      .f_o_flush      (flush)
   );

   fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .f_clk          (clk),
      .f_rst          (rst2),
      .f_o_imem_req   (req2),
      .f_o_imem_addr  (addr2),
      .f_i_imem_ack   (ack2),
      .f_i_imem_instr (32'h1234_5678),
      .f_i_change_pc  (1'b0),
      .f_i_pc_target  (32'h0),
      .f_i_stall      (1'b0),
      .f_o_instr      (instr2),
      .f_o_pc         (opc2),
      .f_o_ce         (ce2),
      .f_o_flush      (flush2)
   );

   typedef struct {
      logic        ack;
      logic        stall;
      logic        chg;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ce;
      logic [31:0] e_pc;
      logic        e_flush;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vt [26];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
   endtask

   task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                          input logic e_ce, input logic [31:0] e_pc, input logic e_flush,
                          input logic [31:0] e_instr);
      chk($sformatf("v%0d req", idx),   {31'b0, req},   {31'b0, e_req});
      chk($sformatf("v%0d addr", idx),  addr,           e_addr);
      chk($sformatf("v%0d ce", idx),    {31'b0, ce},    {31'b0, e_ce});
      chk($sformatf("v%0d pc", idx),    opc,            e_pc);
      chk($sformatf("v%0d flush", idx), {31'b0, flush}, {31'b0, e_flush});
      chk($sformatf("v%0d instr", idx), instr,          e_instr);
   endtask

   initial begin
      //        ack   stl   chg   tgt            req   addr           ce    pc             fl    instr
      vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, NOP_C};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 1'b0, 32'hA000_0000};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b0, 32'hA000_0004};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 1'b0, 32'hA000_0008};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 1'b0, 32'hA000_0008};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 1'b0, 32'hA000_0008};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 1'b0, 32'hA000_0008};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0, 32'hA000_000C};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0, 32'hA000_000C};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b1, 32'h0000_000C, 1'b0, 32'hA000_000C};
      vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010, 1'b0, 32'hA000_0010};
      vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010, 1'b0, 32'hA000_0010};
      vt[12] = '{1'b0, 1'b0, 1'b1, 32'h100,      1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010, 1'b1, NOP_C};
      vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010, 1'b0, NOP_C};
      vt[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h0000_0010, 1'b0, NOP_C};
      vt[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 1'b0, 32'hA000_0100};
      vt[16] = '{1'b1, 1'b0, 1'b1, 32'h40,       1'b1, 32'h0000_0040, 1'b0, 32'h0000_0100, 1'b1, NOP_C};
      vt[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0044, 1'b1, 32'h0000_0040, 1'b0, 32'hA000_0040};
      vt[18] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0044, 1'b1, 32'h0000_0040, 1'b0, 32'hA000_0040};
      vt[19] = '{1'b0, 1'b1, 1'b1, 32'h203,      1'b1, 32'h0000_0200, 1'b0, 32'h0000_0040, 1'b1, NOP_C};
      vt[20] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200, 1'b0, 32'hA000_0200};
      vt[21] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200, 1'b0, 32'hA000_0200};
      vt[22] = '{1'b0, 1'b0, 1'b1, 32'h300,      1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200, 1'b1, NOP_C};
      vt[23] = '{1'b0, 1'b0, 1'b1, 32'h400,      1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200, 1'b1, NOP_C};
      vt[24] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0400, 1'b0, 32'h0000_0200, 1'b0, NOP_C};
      vt[25] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0404, 1'b1, 32'h0000_0400, 1'b0, 32'hA000_0400};

      // Reset state, including the wrap-around instance.
      repeat (2) @(negedge clk);
      chk("rst2 addr", addr2, 32'hFFFF_FFFC);
      chk("rst2 req", {31'b0, req2}, 32'h0);
      rst  = 1'b0;
      rst2 = 1'b0;
      #1;
      chk_all(-1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, NOP_C);

      for (int i = 0; i < 26; i++) begin
         ack   = vt[i].ack;
         stall = vt[i].stall;
         chg   = vt[i].chg;
         tgt   = vt[i].tgt;
         @(posedge clk);
         #1;
         chk_all(i, vt[i].e_req, vt[i].e_addr, vt[i].e_ce, vt[i].e_pc, vt[i].e_flush, vt[i].e_instr);
         @(negedge clk);
      end

      // Asynchronous reset between edges while fetching with ce=1.
      ack = 1'b0; stall = 1'b0; chg = 1'b0; tgt = '0;
      #2 rst = 1'b1;
      #1;
      chk("async req", {31'b0, req}, 32'h0);
      chk("async ce", {31'b0, ce}, 32'h0);
      chk("async addr", addr, 32'h0);
      chk("async instr", instr, NOP_C);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post-rst req", {31'b0, req}, 32'h1);
      @(negedge clk);
      chg = 1'b1; tgt = 32'h80;
      @(posedge clk); #1;
      chk("pre-rst flush", {31'b0, flush}, 32'h1);
      @(negedge clk);
      chg = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("async flush", {31'b0, flush}, 32'h0);
      chk("async req2", {31'b0, req}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // PC wrap: fetch at 0xFFFFFFFC, next address is 0.
      chk("wrap req", {31'b0, req2}, 32'h1);
      chk("wrap addr0", addr2, 32'hFFFF_FFFC);
      ack2 = 1'b1;
      @(posedge clk); #1;
      chk("wrap addr1", addr2, 32'h0);
      chk("wrap pc", opc2, 32'hFFFF_FFFC);
      chk("wrap ce", {31'b0, ce2}, 32'h1);
      chk("wrap instr", instr2, 32'h1234_5678);
      chk("wrap flush", {31'b0, flush2}, 32'h0);
      @(negedge clk);
      ack2 = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
